// File: rtl/perif_regbank_p.sv
// perif_regbank_p
// AXI4-Lite slave register bank. It holds NUM_REGS 32-bit registers, and each
// register works in one of three modes:
//   - read-write, loaded from RESET_VALS at reset;
//   - read-only, which mirrors reg_in;
//   - sticky status (W1C): set from reg_in, cleared by writing 1s.
//
// Ports:
//   s00_axi_aclk, s00_axi_areset : clock and synchronous active-high reset
//   s00_axi_aw* / w* / b*        : AXI4-Lite write address, data and response
//   s00_axi_ar* / r*             : AXI4-Lite read address and data
//   reg_out  : current register contents, register i at [32i+31:32i]
//   reg_in   : read-only values / sticky set bits, same packing as reg_out
//   wr_pulse : one-cycle strobe per register after an OKAY write that lands
//   irq      : registered OR of every sticky status bit
module perif_regbank_p #(
  parameter int                     NUM_REGS   = 4,
  parameter int                     ADDR_WIDTH = 4,
  parameter logic [NUM_REGS-1:0]    RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]    W1C_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VALS = '0
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_areset,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_awaddr,
  input  logic [2:0]               s00_axi_awprot,
  input  logic                     s00_axi_awvalid,
  output logic                     s00_axi_awready,
  input  logic [31:0]              s00_axi_wdata,
  input  logic [3:0]               s00_axi_wstrb,
  input  logic                     s00_axi_wvalid,
  output logic                     s00_axi_wready,
  output logic [1:0]               s00_axi_bresp,
  output logic                     s00_axi_bvalid,
  input  logic                     s00_axi_bready,
  input  logic [ADDR_WIDTH-1:0]    s00_axi_araddr,
  input  logic [2:0]               s00_axi_arprot,
  input  logic                     s00_axi_arvalid,
  output logic                     s00_axi_arready,
  output logic [31:0]              s00_axi_rdata,
  output logic [1:0]               s00_axi_rresp,
  output logic                     s00_axi_rvalid,
  input  logic                     s00_axi_rready,
  output logic [NUM_REGS*32-1:0]   reg_out,
  input  logic [NUM_REGS*32-1:0]   reg_in,
  output logic [NUM_REGS-1:0]      wr_pulse,
  output logic                     irq
);

  localparam int               IDX_W      = ADDR_WIDTH - 2;
  localparam int               SLOTS      = 1 << IDX_W;
  localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  // Write holding slots
  logic              aw_full;
  logic              w_full;
  logic [IDX_W-1:0]  aw_idx;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [31:0]       wmask;
  logic              commit;
  logic              aw_ok;

  // Read decode and per-register views
  logic [IDX_W-1:0]  ar_idx;
  logic              ar_ok;
  logic [31:0]       cur_val [SLOTS];
  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] w1c_nonzero;

  // The protection bits and the byte-offset address bits carry no meaning
  // here. They are folded into a sink so that it is clear they are unused
  // on purpose.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0], reg_in};

  assign s00_axi_awready = ~aw_full;
  assign s00_axi_wready  = ~w_full;
  assign s00_axi_arready = ~s00_axi_rvalid;

  // A write commits once both halves are held and the previous response has
  // been taken. This keeps a single response outstanding at any time.
  assign commit = aw_full & w_full & ~s00_axi_bvalid;
  assign aw_ok  = {1'b0, aw_idx} < NUM_REGS_W;
  assign ar_idx = s00_axi_araddr[ADDR_WIDTH-1:2];
  assign ar_ok  = {1'b0, ar_idx} < NUM_REGS_W;
  assign wmask  = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

  // The AW and W halves are captured independently, in any order. A slot is
  // full only when its ready is low, so a capture can never coincide with
  // the commit that frees the same slot.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (s00_axi_awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_idx  <= s00_axi_awaddr[ADDR_WIDTH-1:2];
      end
      if (s00_axi_wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= s00_axi_wdata;
        w_strb <= s00_axi_wstrb;
      end
    end
  end

  // Write response and write strobes. A read-only target still answers
  // OKAY, but it raises no strobe.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
      wr_pulse       <= '0;
    end else begin
      wr_pulse <= hit & ~RO_MASK;
      if (commit) begin
        s00_axi_bvalid <= 1'b1;
        s00_axi_bresp  <= aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s00_axi_bvalid && s00_axi_bready) begin
        s00_axi_bvalid <= 1'b0;
      end
    end
  end

  // Per-register storage. Address slots beyond NUM_REGS read as zero, which
  // keeps the read mux a plain power-of-two lookup.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    if (i < NUM_REGS) begin : g_live
      assign hit[i] = commit && (aw_idx == IDX_W'(i));

      if (RO_MASK[i]) begin : g_ro
        assign cur_val[i]     = reg_in[32*i +: 32];
        assign w1c_nonzero[i] = 1'b0;
      end else if (W1C_MASK[i]) begin : g_w1c
        logic [31:0] stored;
        logic [31:0] clr;
        assign clr = hit[i] ? (w_data & wmask) : 32'h0;

        // The set is applied after the clear, so a hardware set wins over
        // a software clear on the same bit in the same cycle.
        always_ff @(posedge s00_axi_aclk) begin
          if (s00_axi_areset) begin
            stored <= 32'h0;
          end else begin
            stored <= (stored & ~clr) | reg_in[32*i +: 32];
          end
        end

        assign cur_val[i]     = stored;
        assign w1c_nonzero[i] = |stored;
      end else begin : g_rw
        logic [31:0] stored;

        always_ff @(posedge s00_axi_aclk) begin
          if (s00_axi_areset) begin
            stored <= RESET_VALS[32*i +: 32];
          end else if (hit[i]) begin
            stored <= (stored & ~wmask) | (w_data & wmask);
          end
        end

        assign cur_val[i]     = stored;
        assign w1c_nonzero[i] = 1'b0;
      end

      assign reg_out[32*i +: 32] = cur_val[i];
    end else begin : g_hole
      assign cur_val[i] = 32'h0;
    end
  end

  // The read data is registered at the AR edge from the values in place
  // before that edge. A write committing on the same edge therefore does
  // not affect what this read returns.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= 32'h0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (s00_axi_arvalid && !s00_axi_rvalid) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= ar_ok ? cur_val[ar_idx] : 32'h0;
      s00_axi_rresp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s00_axi_rvalid && s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

  // Interrupt follows the sticky status one cycle late
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      irq <= 1'b0;
    end else begin
      irq <= |w1c_nonzero;
    end
  end

endmodule

// File: tb/tb_perif_regbank_p.sv
// tb_perif_regbank_p
// Bench for perif_regbank_p, configured with six registers:
//   - 0..3 read-write;
//   - 4 sticky status (W1C);
//   - 5 read-only.
// Addresses 0x18 and 0x1C decode to no register. A transaction-level model
// tracks what every output must be. A negedge process compares the DUT
// against that model on every cycle. Directed sequences also pin literal
// values.
module tb_perif_regbank_p;

  localparam int NREG = 6;
  localparam logic [NREG*32-1:0] RV = {32'h0BADF00D, 32'hFFFF0000, 32'hDEADBEEF,
                                       32'h00000000, 32'hCAFEF00D, 32'h12345678};

  logic              clk;
  logic              areset;
  logic [4:0]        awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [4:0]        araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NREG*32-1:0] reg_out;
  logic [NREG*32-1:0] reg_in;
  logic [NREG-1:0]   wr_pulse;
  logic              irq;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;
  int pulse_cnt [NREG];

  perif_regbank_p #(
    .NUM_REGS   (NREG),
    .ADDR_WIDTH (5),
    .RO_MASK    (6'b100000),
    .W1C_MASK   (6'b010000),
    .RESET_VALS (RV)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_areset  (areset),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .reg_out         (reg_out),
    .reg_in          (reg_in),
    .wr_pulse        (wr_pulse),
    .irq             (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value against its expectation and keep the tally
  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the slots, the outstanding responses and the register
  // contents. It advances once per rising edge, from the inputs in place
  // before that edge.
  logic [31:0] m_regs [NREG];
  logic [31:0] m_old  [NREG];
  bit          m_aw_full, m_w_full, m_bvalid, m_rvalid, m_irq;
  bit          m_old_aw, m_old_w;
  int          m_aw_idx, m_idx;
  logic [31:0] m_w_data, m_mask, m_rdata;
  logic [3:0]  m_w_strb;
  logic [1:0]  m_bresp, m_rresp;
  logic [NREG-1:0] m_pulse;

  always @(posedge clk) begin
    if (areset) begin
      for (int i = 0; i < NREG; i++) m_regs[i] = (i == 4) ? 32'h0 : RV[32*i +: 32];
      m_aw_full = 0; m_w_full = 0; m_bvalid = 0; m_rvalid = 0; m_irq = 0;
      m_bresp = 2'b00; m_rresp = 2'b00; m_rdata = 32'h0; m_pulse = '0;
    end else begin
      m_old    = m_regs;
      m_old_aw = m_aw_full;
      m_old_w  = m_w_full;
      m_irq    = (m_old[4] != 32'h0);

      if (!m_rvalid && arvalid) begin
        m_idx    = int'(araddr[4:2]);
        m_rvalid = 1;
        if (m_idx >= NREG) begin
          m_rdata = 32'h0; m_rresp = 2'b10;
        end else begin
          m_rdata = (m_idx == 5) ? reg_in[191:160] : m_old[m_idx];
          m_rresp = 2'b00;
        end
      end else if (m_rvalid && rready) begin
        m_rvalid = 0;
      end

      m_pulse = '0;
      if (m_old_aw && m_old_w && !m_bvalid) begin
        m_bvalid = 1; m_aw_full = 0; m_w_full = 0;
        for (int b = 0; b < 4; b++) m_mask[8*b +: 8] = m_w_strb[b] ? 8'hFF : 8'h00;
        if (m_aw_idx >= NREG) begin
          m_bresp = 2'b10;
        end else begin
          m_bresp = 2'b00;
          if (m_aw_idx == 4) begin
            m_regs[4] = m_old[4] & ~(m_w_data & m_mask);
            m_pulse[4] = 1'b1;
          end else if (m_aw_idx != 5) begin
            m_regs[m_aw_idx] = (m_old[m_aw_idx] & ~m_mask) | (m_w_data & m_mask);
            m_pulse[m_aw_idx] = 1'b1;
          end
        end
      end else if (m_bvalid && bready) begin
        m_bvalid = 0;
      end

      if (!m_old_aw && awvalid) begin
        m_aw_full = 1; m_aw_idx = int'(awaddr[4:2]);
      end
      if (!m_old_w && wvalid) begin
        m_w_full = 1; m_w_data = wdata; m_w_strb = wstrb;
      end

      m_regs[4] = m_regs[4] | reg_in[159:128];
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("awready", awready, !m_aw_full);
      checkOutput("wready", wready, !m_w_full);
      checkOutput("arready", arready, !m_rvalid);
      checkOutput("bvalid", bvalid, m_bvalid);
      checkOutput("bresp", bresp, m_bresp);
      checkOutput("rvalid", rvalid, m_rvalid);
      checkOutput("rdata", rdata, m_rdata);
      checkOutput("rresp", rresp, m_rresp);
      checkOutput("wr_pulse", wr_pulse, m_pulse);
      checkOutput("irq", irq, m_irq);
      checkOutput("reg_out", reg_out, {reg_in[191:160], m_regs[4], m_regs[3],
                                       m_regs[2], m_regs[1], m_regs[0]});
    end
  end

  // Count strobes per register
  always @(negedge clk) begin
    for (int i = 0; i < NREG; i++) if (wr_pulse[i]) pulse_cnt[i]++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Take one write response with bready high
  task automatic wait_b(output logic [1:0] resp);
    bit seen;
    seen = 0;
    resp = 2'b11;
    bready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bvalid) begin
        resp = bresp; seen = 1; tick(); break;
      end
      tick();
    end
    bready = 1'b0;
    if (!seen) checkOutput("b_timeout", 1'b0, 1'b1);
  endtask

  // Full write: AW and W offered together, then the response is taken
  task automatic applyStimulus(input logic [4:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done, w_done, hs_aw, hs_w;
    aw_done = 0; w_done = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    for (int c = 0; c < 40 && !(aw_done && w_done); c++) begin
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1; end
      if (hs_w)  begin wvalid  = 1'b0; w_done  = 1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) checkOutput("aw_w_timeout", 1'b0, 1'b1);
    wait_b(resp);
  endtask

  task automatic do_read(input logic [4:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    bit hs, done;
    done = 0; data = 32'hX; resp = 2'b11;
    araddr = addr; arvalid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      hs = arready;
      tick();
      if (hs) begin done = 1; break; end
    end
    arvalid = 1'b0;
    if (!done) checkOutput("ar_timeout", 1'b0, 1'b1);
    done = 0;
    rready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (rvalid) begin
        data = rdata; resp = rresp; done = 1; tick(); break;
      end
      tick();
    end
    rready = 1'b0;
    if (!done) checkOutput("r_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [31:0] exp_vals [4];
    int          total;

    areset = 1'b1; awaddr = '0; awprot = 3'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0; reg_in = '0;
    for (int i = 0; i < NREG; i++) pulse_cnt[i] = 0;

    $display("[TB] reset");
    tick();
    cmp_en = 1;
    tick(); tick();
    areset = 1'b0;
    tick();
    checkOutput("rst_regs", reg_out[127:0],
                {32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D, 32'h12345678});
    checkOutput("rst_w1c", reg_out[159:128], 32'h0);
    checkOutput("rst_ready", {awready, wready, arready}, 3'b111);
    checkOutput("rst_valid", {bvalid, rvalid, irq}, 3'b000);

    $display("[TB] compatibility writes");
    exp_vals = '{32'h1, 32'h2, 32'h3, 32'h4};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5'(4 * i), exp_vals[i], 4'hF, resp);
      checkOutput("compat_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), data, resp);
      checkOutput("compat_rdata", data, exp_vals[i]);
      checkOutput("compat_rresp", resp, 2'b00);
      checkOutput("compat_pulses", pulse_cnt[i], 1);
    end

    $display("[TB] byte strobes");
    applyStimulus(5'h04, 32'hAABBCCDD, 4'hF, resp);
    applyStimulus(5'h04, 32'h11223344, 4'b0101, resp);
    do_read(5'h04, data, resp);
    checkOutput("strobe_rdata", data, 32'hAA22CC44);

    $display("[TB] channel skew and back-pressure");
    bready = 1'b0;
    wdata = 32'h55; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick();
    checkOutput("skew_wready_low", wready, 1'b0);
    checkOutput("skew_no_commit", bvalid, 1'b0);
    awaddr = 5'h0C; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      checkOutput("stall_bvalid", bvalid, 1'b1);
      if (k == 0) begin
        awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
      end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end
    checkOutput("stall_reg0_old", reg_out[31:0], 32'h1);
    checkOutput("stall_aw_full", awready, 1'b0);
    wait_b(resp);
    checkOutput("stall_bresp1", resp, 2'b00);
    wait_b(resp);
    checkOutput("stall_bresp2", resp, 2'b00);
    do_read(5'h0C, data, resp);
    checkOutput("skew_reg3", data, 32'h55);
    do_read(5'h00, data, resp);
    checkOutput("skew_reg0", data, 32'h77);
    checkOutput("skew_pulse3", pulse_cnt[3], 2);

    $display("[TB] read and write same register");
    awaddr = 5'h08; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 5'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checkOutput("rw_same_old", rdata, 32'h3);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    wait_b(resp);
    do_read(5'h08, data, resp);
    checkOutput("rw_same_new", data, 32'hA5A5A5A5);

    $display("[TB] decode error");
    applyStimulus(5'h18, 32'hFFFFFFFF, 4'hF, resp);
    checkOutput("dec_bresp", resp, 2'b10);
    do_read(5'h18, data, resp);
    checkOutput("dec_rdata", data, 32'h0);
    checkOutput("dec_rresp", resp, 2'b10);
    do_read(5'h1C, data, resp);
    checkOutput("dec_rresp_1c", resp, 2'b10);
    total = 0;
    for (int i = 0; i < NREG; i++) total += pulse_cnt[i];
    checkOutput("dec_pulse_total", total, 9);
    checkOutput("dec_regs", reg_out[127:0],
                {32'h00000055, 32'hA5A5A5A5, 32'hAA22CC44, 32'h00000077});

    $display("[TB] read-only register");
    reg_in[191:160] = 32'h13572468;
    #1;
    checkOutput("ro_mirror", reg_out[191:160], 32'h13572468);
    do_read(5'h14, data, resp);
    checkOutput("ro_rdata", data, 32'h13572468);
    applyStimulus(5'h14, 32'h0, 4'hF, resp);
    checkOutput("ro_bresp", resp, 2'b00);
    checkOutput("ro_no_pulse", pulse_cnt[5], 0);

    $display("[TB] sticky status and irq");
    reg_in[159:128] = 32'h5;
    tick();
    reg_in[159:128] = 32'h0;
    tick();
    checkOutput("w1c_irq_set", irq, 1'b1);
    do_read(5'h10, data, resp);
    checkOutput("w1c_set", data, 32'h5);
    applyStimulus(5'h10, 32'h1, 4'hF, resp);
    do_read(5'h10, data, resp);
    checkOutput("w1c_clear1", data, 32'h4);
    reg_in[159:128] = 32'h4;
    applyStimulus(5'h10, 32'h4, 4'hF, resp);
    reg_in[159:128] = 32'h0;
    do_read(5'h10, data, resp);
    checkOutput("w1c_set_wins", data, 32'h4);
    applyStimulus(5'h10, 32'h4, 4'hF, resp);
    checkOutput("w1c_pulse", pulse_cnt[4], 3);
    do_read(5'h10, data, resp);
    checkOutput("w1c_cleared", data, 32'h0);
    checkOutput("w1c_irq_clr", irq, 1'b0);

    $display("[TB] reset mid-write");
    awaddr = 5'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    areset = 1'b1;
    tick(); tick();
    areset = 1'b0;
    checkOutput("mid_rst_bvalid", bvalid, 1'b0);
    checkOutput("mid_rst_regs", reg_out[159:0],
                {32'h0, 32'hDEADBEEF, 32'h00000000, 32'hCAFEF00D, 32'h12345678});
    wdata = 32'h99; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick(); tick(); tick();
    checkOutput("mid_rst_no_commit", bvalid, 1'b0);
    checkOutput("mid_rst_reg1", reg_out[63:32], 32'hCAFEF00D);
    awaddr = 5'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wait_b(resp);
    checkOutput("post_rst_bresp", resp, 2'b00);
    do_read(5'h08, data, resp);
    checkOutput("post_rst_reg2", data, 32'h99);

    tick(); tick();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
